// File: rtl/vm_pkg.sv
// Shared types and coin helpers for the vending-machine sequencer and its
// change-picking logic.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vm_state_e;

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_2  = 2'd1;
  localparam logic [1:0] COIN_5  = 2'd2;
  localparam logic [1:0] COIN_10 = 2'd3;

  // Widest remaining amount the change picker understands.
  localparam int PICK_W = 16;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] v;
    case (code)
      COIN_1:  v = 4'd1;
      COIN_2:  v = 4'd2;
      COIN_5:  v = 4'd5;
      default: v = 4'd10;
    endcase
    return v;
  endfunction

  // Largest dispensable coin not exceeding the remaining change.
  function automatic logic [3:0] pick_coin(input logic [PICK_W-1:0] remaining);
    logic [3:0] c;
    if (remaining >= PICK_W'(10))      c = 4'd10;
    else if (remaining >= PICK_W'(5))  c = 4'd5;
    else if (remaining >= PICK_W'(2))  c = 4'd2;
    else if (remaining >= PICK_W'(1))  c = 4'd1;
    else                               c = 4'd0;
    return c;
  endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Combinational change-coin selector: remaining amount -> next coin to pay out.
module vm_change_picker
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 9
) (
  input  logic [CREDIT_W-1:0] remaining,
  output logic [3:0]          remcach
);

  logic [PICK_W-1:0] rem_ext;

  assign rem_ext = PICK_W'(remaining);
  assign remcach = pick_coin(rem_ext);

endmodule

// File: rtl/vm_sequencer.sv
// Vending-machine sequencing controller: coin credit, vend pulse, change payout.
// Optional inactivity refund in COLLECT is enabled with `define VM_TIMEOUT_EN.
module vm_sequencer
  import vm_pkg::*;
#(
  parameter int PRICE          = 13,
  parameter int CREDIT_W       = 9,
  parameter int MAX_CREDIT     = 255,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  output logic                coin_ready,
  output logic                coin_reject,
  input  logic                buy,
  input  logic                cancel,
  output logic                conclusion,
  output logic [3:0]          remcach,
  output logic                chg_valid,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    PRICE_S = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]    MAX_S   = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vm_state_e           state, state_nxt;
  logic [CREDIT_W-1:0] credit_q, credit_nxt;
  logic                reject_q, reject_nxt;
  logic [3:0]          pick;
  logic [3:0]          coin_val;
  logic                coin_acc;
  logic                coin_fits;
  logic [SUM_W-1:0]    sum_coin;
  logic [SUM_W-1:0]    eff_sum;
  logic                timeout;
  logic                quit;

  function automatic logic fits_max(input logic [SUM_W-1:0] s);
    return s <= MAX_S;
  endfunction

  // In CHANGE the credit register holds the remaining change.
  vm_change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
    .remaining (credit_q),
    .remcach   (pick)
  );

  assign coin_val  = coin_value(coin_code);
  assign coin_acc  = coin_valid && coin_ready;
  assign sum_coin  = {1'b0, credit_q} + SUM_W'(coin_val);
  assign coin_fits = fits_max(sum_coin);
  assign eff_sum   = (coin_acc && coin_fits) ? sum_coin : {1'b0, credit_q};
  assign quit      = cancel || timeout;

`ifdef VM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt;

  assign timeout = (state == COLLECT) && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if ((state != COLLECT) || coin_acc || buy || timeout)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit_q <= credit_nxt;
      reject_q <= reject_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit_q;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (coin_acc) begin
          if (coin_fits) begin
            state_nxt  = COLLECT;
            credit_nxt = eff_sum[CREDIT_W-1:0];
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        reject_nxt = coin_acc && !coin_fits;
        credit_nxt = eff_sum[CREDIT_W-1:0];
        // Cancel (or timeout) wins over buy; both see the same-cycle coin.
        if (quit)
          state_nxt = CHANGE;
        else if (buy && (eff_sum >= PRICE_S))
          state_nxt = VEND;
      end
      VEND: begin
        credit_nxt = credit_q - PRICE_C;
        state_nxt  = (credit_q == PRICE_C) ? IDLE : CHANGE;
      end
      CHANGE: begin
        if (chg_ready) begin
          credit_nxt = credit_q - CREDIT_W'(pick);
          if (credit_q == CREDIT_W'(pick))
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    coin_ready = 1'b0;
    conclusion = 1'b0;
    chg_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, COLLECT: coin_ready = 1'b1;
      VEND: begin
        conclusion = 1'b1;
        busy       = 1'b1;
      end
      CHANGE: begin
        chg_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign remcach     = chg_valid ? pick : 4'd0;
  assign credit      = credit_q;
  assign coin_reject = reject_q;

endmodule

// File: tb/tb_vm_sequencer.sv
// Scoreboard bench for vm_sequencer: transaction-level credit model, event
// queues for vend / reject / change coins, and a decoupled output monitor.
module tb_vm_sequencer;

  localparam int PRICE      = 13;
  localparam int CREDIT_W   = 9;
  localparam int MAX_CREDIT = 255;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                coin_valid = 1'b0;
  logic [1:0]          coin_code = 2'd0;
  logic                coin_ready;
  logic                coin_reject;
  logic                buy = 1'b0;
  logic                cancel = 1'b0;
  logic                conclusion;
  logic [3:0]          remcach;
  logic                chg_valid;
  logic                chg_ready;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  always #5 clk = ~clk;

  vm_sequencer #(
    .PRICE(PRICE), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_ready(coin_ready), .coin_reject(coin_reject), .buy(buy), .cancel(cancel),
    .conclusion(conclusion), .remcach(remcach), .chg_valid(chg_valid),
    .chg_ready(chg_ready), .credit(credit), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int vend_q[$];
  int rej_q[$];
  int chg_q[$];
  int model_credit = 0;
  int stall_want = 0;
  bit rdy_random = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (unexpected event or expired bound)", name);
  endtask

  function automatic int denom(input int code);
    int v;
    case (code)
      0: v = 1;
      1: v = 2;
      2: v = 5;
      default: v = 10;
    endcase
    return v;
  endfunction

  function automatic int largest_coin(input int amt);
    int coins[4] = '{10, 5, 2, 1};
    int r = 0;
    for (int i = 3; i >= 0; i--)
      if (coins[i] <= amt) r = coins[i];
    return r;
  endfunction

  task automatic expect_change(input int amt);
    int left = amt;
    while (left > 0) begin
      chg_q.push_back(largest_coin(left));
      left -= largest_coin(left);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_credit"}, int'(credit), 0);
    check({tag, "_conclusion"}, int'(conclusion), 0);
    check({tag, "_coin_reject"}, int'(coin_reject), 0);
    check({tag, "_chg_valid"}, int'(chg_valid), 0);
    check({tag, "_remcach"}, int'(remcach), 0);
    check({tag, "_coin_ready"}, int'(coin_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // One request cycle; the model predicts events, then waits for the DUT to settle.
  task automatic do_txn(input bit cv, input int code, input bit b, input bit c,
                        output int busy_cycles);
    int val;
    int eff;
    bit idle;
    val  = denom(code);
    eff  = model_credit;
    idle = (model_credit == 0);
    if (cv) begin
      if (eff + val <= MAX_CREDIT) eff += val;
      else rej_q.push_back(model_credit);
    end
    if (!idle) begin
      if (c) begin
        expect_change(eff);
        eff = 0;
      end else if (b && eff >= PRICE) begin
        vend_q.push_back(eff);
        expect_change(eff - PRICE);
        eff = 0;
      end
    end
    model_credit = eff;
    coin_valid = cv;
    coin_code  = 2'(code);
    buy        = b;
    cancel     = c;
    @(negedge clk);
    coin_valid = 1'b0;
    buy        = 1'b0;
    cancel     = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 400) begin
      @(negedge clk);
      busy_cycles++;
    end
    if (busy) flag_fail("busy_bound");
    check("credit", int'(credit), model_credit);
  endtask

  // Change-dispenser model: optional forced stall at the start of each payout.
  initial begin
    int stalled = 0;
    chg_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!chg_valid) stalled = 0;
      if (chg_valid && stalled < stall_want) begin
        chg_ready = 1'b0;
        stalled++;
      end else begin
        chg_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    bit prev_stall = 1'b0;
    int prev_rem = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (coin_reject) begin
          if (rej_q.size() == 0) flag_fail("unexpected_reject");
          else check("reject_credit", int'(credit), rej_q.pop_front());
        end
        if (conclusion) begin
          if (vend_q.size() == 0) flag_fail("unexpected_vend");
          else check("vend_credit", int'(credit), vend_q.pop_front());
        end
        if (prev_stall && chg_valid) check("remcach_hold", int'(remcach), prev_rem);
        if (chg_valid && chg_ready) begin
          if (chg_q.size() == 0) flag_fail("unexpected_change");
          else check("change_coin", int'(remcach), chg_q.pop_front());
        end
        prev_stall = chg_valid && !chg_ready;
        prev_rem   = int'(remcach);
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int bc;
    int op;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Exact price: 10+2+1, single vend, no change.
    do_txn(1'b1, 3, 1'b0, 1'b0, bc);
    do_txn(1'b1, 1, 1'b0, 1'b0, bc);
    do_txn(1'b1, 0, 1'b0, 1'b0, bc);
    do_txn(1'b0, 0, 1'b1, 1'b0, bc);
    check("exact_busy_cycles", bc, 1);

    // 20 credit: vend then 5, 2 back to back.
    do_txn(1'b1, 3, 1'b0, 1'b0, bc);
    do_txn(1'b1, 3, 1'b0, 1'b0, bc);
    do_txn(1'b0, 0, 1'b1, 1'b0, bc);
    check("change_busy_cycles", bc, 3);

    // Insufficient buy, then cancel with a 3-cycle dispenser stall.
    do_txn(1'b1, 2, 1'b0, 1'b0, bc);
    do_txn(1'b1, 1, 1'b0, 1'b0, bc);
    do_txn(1'b0, 0, 1'b1, 1'b0, bc);
    stall_want = 3;
    do_txn(1'b0, 0, 1'b0, 1'b1, bc);
    check("stall_busy_cycles", bc, 5);
    stall_want = 0;

    // Fill to 250, overflow coin is rejected, then buy+cancel refunds only.
    for (int i = 0; i < 25; i++) do_txn(1'b1, 3, 1'b0, 1'b0, bc);
    do_txn(1'b1, 3, 1'b0, 1'b0, bc);
    do_txn(1'b0, 0, 1'b1, 1'b1, bc);

    // Reset in the middle of a stalled payout of 8.
    do_txn(1'b1, 3, 1'b0, 1'b0, bc);
    do_txn(1'b1, 3, 1'b0, 1'b0, bc);
    do_txn(1'b1, 0, 1'b0, 1'b0, bc);
    vend_q.push_back(21);
    stall_want = 1000;
    buy = 1'b1;
    @(negedge clk);
    buy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_credit", int'(credit), 21 - PRICE);
    check("pre_reset_remcach", int'(remcach), largest_coin(21 - PRICE));
    #3 rst_n = 1'b0;
    #1 check_reset("midreset");
    chg_q.delete();
    model_credit = 0;
    stall_want = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized transactions with a randomly stalling dispenser.
    rdy_random = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2, 3, 4: do_txn(1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b0, bc);
        5, 6:          do_txn(1'b0, 0, 1'b1, 1'b0, bc);
        7:             do_txn(1'b0, 0, 1'b0, 1'b1, bc);
        8:             do_txn(1'b1, int'($urandom_range(0, 3)), 1'b1, 1'b0, bc);
        default:       do_txn($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                              1'b1, 1'b1, bc);
      endcase
    end

    repeat (3) @(negedge clk);
    check("vend_q_left", vend_q.size(), 0);
    check("rej_q_left", rej_q.size(), 0);
    check("chg_q_left", chg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
